// File: rtl/sn76489_tone_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sn76489_tone_generator                                         |
// | Brief   : three square-wave tone channels plus LFSR noise, mixed into    |
// |           one unsigned sample. Optional macro SN76489_CHANNEL_OUT_EN     |
// |           adds registered per-channel volume outputs.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sn76489_tone_generator #(
  parameter int CLK_DIV = 16
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic [9:0] freq1,
  input  logic [9:0] freq2,
  input  logic [9:0] freq3,
  input  logic [3:0] att1,
  input  logic [3:0] att2,
  input  logic [3:0] att3,
  input  logic [3:0] attNoise,
  input  logic       noiseFeedbackType,
  input  logic [1:0] noiseFeed,
  output logic [9:0] sample,
  output logic       sampleValid
`ifdef SN76489_CHANNEL_OUT_EN
  ,
  output logic [7:0] ch1Vol,
  output logic [7:0] ch2Vol,
  output logic [7:0] ch3Vol,
  output logic [7:0] chNoiseVol
`endif
);

  localparam logic [7:0]  c_presc_last = 8'(CLK_DIV - 1);
  localparam logic [15:0] c_lfsr_seed  = 16'h8000;

  function automatic logic [7:0] f_vol(input logic [3:0] att);
    logic [7:0] v;
    case (att)
      4'd0:    v = 8'd255;
      4'd1:    v = 8'd203;
      4'd2:    v = 8'd161;
      4'd3:    v = 8'd128;
      4'd4:    v = 8'd102;
      4'd5:    v = 8'd81;
      4'd6:    v = 8'd64;
      4'd7:    v = 8'd51;
      4'd8:    v = 8'd40;
      4'd9:    v = 8'd32;
      4'd10:   v = 8'd26;
      4'd11:   v = 8'd20;
      4'd12:   v = 8'd16;
      4'd13:   v = 8'd13;
      4'd14:   v = 8'd10;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Prescaler
  logic [7:0] r_presc;
  logic       w_tick;

  assign w_tick = (r_presc == c_presc_last);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset)     r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 8'd1;
  end

  // Tone channels
  logic [9:0] w_freq      [3];
  logic [9:0] r_tone_cnt  [3];
  logic       r_tone_ff   [3];
  logic       w_tone_next [3];
  logic       w_tone_out  [3];

  assign w_freq[0] = freq1;
  assign w_freq[1] = freq2;
  assign w_freq[2] = freq3;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_tone
      logic w_reload;

      assign w_reload       = w_tick && (r_tone_cnt[i] <= 10'd1);
      assign w_tone_next[i] = w_reload ? ~r_tone_ff[i] : r_tone_ff[i];
      // Half-periods of 0 or 1 are inaudible; the channel becomes a DC level.
      assign w_tone_out[i]  = (w_freq[i] <= 10'd1) ? 1'b1 : r_tone_ff[i];

      always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
          r_tone_cnt[i] <= '0;
          r_tone_ff[i]  <= 1'b0;
        end else if (w_tick) begin
          r_tone_cnt[i] <= w_reload ? w_freq[i] : r_tone_cnt[i] - 10'd1;
          r_tone_ff[i]  <= w_tone_next[i];
        end
      end
    end
  endgenerate

  // Noise clock
  logic [6:0] r_noise_cnt;
  logic [6:0] w_noise_last;
  logic       r_noise_ff;
  logic       w_noise_next;
  logic       w_shift;

  always_comb begin
    w_noise_last = 7'd63;
    case (noiseFeed)
      2'b00:   w_noise_last = 7'd15;
      2'b01:   w_noise_last = 7'd31;
      default: w_noise_last = 7'd63;
    endcase
  end

  always_comb begin
    w_noise_next = r_noise_ff;
    if (noiseFeed == 2'b11)
      w_noise_next = w_tone_next[2];
    else if (w_tick && (r_noise_cnt >= w_noise_last))
      w_noise_next = ~r_noise_ff;
  end

  assign w_shift = !r_noise_ff && w_noise_next;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_noise_cnt <= '0;
      r_noise_ff  <= 1'b0;
    end else begin
      r_noise_ff <= w_noise_next;
      // >= keeps the counter sane when the rate drops below the current count
      if (w_tick && (noiseFeed != 2'b11))
        r_noise_cnt <= (r_noise_cnt >= w_noise_last) ? 7'd0 : r_noise_cnt + 7'd1;
    end
  end

  // Noise LFSR
  logic [15:0] r_lfsr;
  logic [2:0]  r_noise_ctrl;
  logic [2:0]  w_noise_ctrl;
  logic        w_feedback;

  assign w_noise_ctrl = {noiseFeedbackType, noiseFeed};
  assign w_feedback   = noiseFeedbackType ? (r_lfsr[0] ^ r_lfsr[3]) : r_lfsr[0];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_lfsr       <= c_lfsr_seed;
      r_noise_ctrl <= '0;
    end else begin
      r_noise_ctrl <= w_noise_ctrl;
      if (w_noise_ctrl != r_noise_ctrl) r_lfsr <= c_lfsr_seed;
      else if (w_shift)                 r_lfsr <= {w_feedback, r_lfsr[15:1]};
    end
  end

  // Mixer
  logic [7:0] w_vol [4];
  logic [9:0] w_sum;
  logic       r_tick_d;
  logic [9:0] r_sample;
  logic       r_valid;

  assign w_vol[0] = w_tone_out[0] ? f_vol(att1)     : 8'd0;
  assign w_vol[1] = w_tone_out[1] ? f_vol(att2)     : 8'd0;
  assign w_vol[2] = w_tone_out[2] ? f_vol(att3)     : 8'd0;
  assign w_vol[3] = r_lfsr[0]     ? f_vol(attNoise) : 8'd0;
  assign w_sum    = {2'b00, w_vol[0]} + {2'b00, w_vol[1]}
                  + {2'b00, w_vol[2]} + {2'b00, w_vol[3]};

  // Sample the clock after the tick so the mix reflects the freshly advanced state.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_tick_d <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_tick_d <= w_tick;
      r_valid  <= r_tick_d;
      if (r_tick_d) r_sample <= w_sum;
    end
  end

  assign sample      = r_sample;
  assign sampleValid = r_valid;

`ifdef SN76489_CHANNEL_OUT_EN
  logic [7:0] r_ch_vol [4];

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 4; i++) r_ch_vol[i] <= '0;
    end else if (r_tick_d) begin
      for (int i = 0; i < 4; i++) r_ch_vol[i] <= w_vol[i];
    end
  end

  assign ch1Vol     = r_ch_vol[0];
  assign ch2Vol     = r_ch_vol[1];
  assign ch3Vol     = r_ch_vol[2];
  assign chNoiseVol = r_ch_vol[3];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sn76489_tone_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sn76489_tone_generator                                      |
// | Brief   : directed self-checking bench for sn76489_tone_generator        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sn76489_tone_generator;

  logic       clock = 1'b0;
  logic       nReset = 1'b1;
  logic [9:0] freq1 = '0, freq2 = '0, freq3 = '0;
  logic [3:0] att1 = 4'd15, att2 = 4'd15, att3 = 4'd15, attNoise = 4'd15;
  logic       noiseFeedbackType = 1'b0;
  logic [1:0] noiseFeed = 2'b00;
  logic [9:0] sample;
  logic       sampleValid;
`ifdef SN76489_CHANNEL_OUT_EN
  logic [7:0] ch1Vol, ch2Vol, ch3Vol, chNoiseVol;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  time t_last_change = 0;

  sn76489_tone_generator #(.CLK_DIV(16)) dut (
    .clock(clock), .nReset(nReset),
    .freq1(freq1), .freq2(freq2), .freq3(freq3),
    .att1(att1), .att2(att2), .att3(att3), .attNoise(attNoise),
    .noiseFeedbackType(noiseFeedbackType), .noiseFeed(noiseFeed),
    .sample(sample), .sampleValid(sampleValid)
`ifdef SN76489_CHANNEL_OUT_EN
    , .ch1Vol(ch1Vol), .ch2Vol(ch2Vol), .ch3Vol(ch3Vol), .chNoiseVol(chNoiseVol)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    nReset = 1'b0;
    repeat (2) @(negedge clock);
    nReset = 1'b1;
  endtask

  task automatic next_sample(output logic [9:0] s, output int gap);
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
    end while (!sampleValid && gap < 64);
    if (!sampleValid) chk("valid_timeout", 32'(sampleValid), 32'd1);
    s = sample;
  endtask

  task automatic wait_lfsr_change(input int bound, output int gap_clk);
    logic [15:0] prev;
    int n;
    prev = dut.r_lfsr;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (dut.r_lfsr === prev && n < bound);
    if (dut.r_lfsr === prev) chk("lfsr_timeout", 32'(dut.r_lfsr), 32'(~prev));
    gap_clk = int'(($time - t_last_change) / 10);
    t_last_change = $time;
  endtask

  initial begin
    logic [9:0]  s;
    logic [15:0] m;
    int          g;
    int          ones;
    logic        found;

    // Reset state
    #3 nReset = 1'b0;
    #4;
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sampleValid), 32'd0);
    chk("rst_lfsr", 32'(dut.r_lfsr), 32'h8000);

    // Tone 1: half-period 4 ticks, full volume
    freq1 = 10'd4; att1 = 4'd0;
    @(negedge clock);
    nReset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      next_sample(s, g);
      chk("t1_sample", 32'(s), ((k / 4) % 2 == 0) ? 32'd255 : 32'd0);
      if (k > 0) chk("t1_gap", 32'(g), 32'd16);
    end
    @(negedge clock);
    chk("t1_valid_pulse", 32'(sampleValid), 32'd0);

    // Tone 2 with half-period 1 is DC at 161
    freq1 = 10'd0; att1 = 4'd15;
    freq2 = 10'd1; att2 = 4'd2;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      next_sample(s, g);
      chk("t2_dc", 32'(s), 32'd161);
    end

    // Periodic noise, shift every 32 ticks
    freq2 = 10'd0; att2 = 4'd15; attNoise = 4'd0;
    noiseFeedbackType = 1'b0; noiseFeed = 2'b00;
    do_reset();
    m = 16'h8000;
    wait_lfsr_change(1200, g);
    m = {m[0], m[15:1]};
    chk("pn_first", 32'(dut.r_lfsr), 32'(m));
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      wait_lfsr_change(1200, g);
      chk("pn_gap", 32'(g), 32'd512);
      m = {m[0], m[15:1]};
      chk("pn_lfsr", 32'(dut.r_lfsr), 32'(m));
      if (m[0]) ones++;
      next_sample(s, g);
      chk("pn_sample", 32'(s), m[0] ? 32'd255 : 32'd0);
    end
    chk("pn_ones", 32'(ones), 32'd1);

    // White noise clocked by tone 3 (half-period 2 ticks)
    noiseFeedbackType = 1'b1; noiseFeed = 2'b11; freq3 = 10'd2; att3 = 4'd15;
    do_reset();
    m = 16'h8000;
    for (int k = 0; k < 100; k++) begin
      wait_lfsr_change(200, g);
      if (k > 0) chk("wn_gap", 32'(g), 32'd64);
      m = {m[0] ^ m[3], m[15:1]};
      chk("wn_lfsr", 32'(dut.r_lfsr), 32'(m));
    end

    // All channels at full volume, then asynchronous reset mid-tick
    noiseFeedbackType = 1'b0; noiseFeed = 2'b11; freq3 = 10'd0;
    att1 = 4'd0; att2 = 4'd0; att3 = 4'd0; attNoise = 4'd0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      next_sample(s, g);
      if (s == 10'd1020) found = 1'b1;
    end
    chk("max_sample", 32'(s), 32'd1020);
    #2 nReset = 1'b0;
    #1;
    chk("async_sample", 32'(sample), 32'd0);
    chk("async_valid", 32'(sampleValid), 32'd0);
    chk("async_lfsr", 32'(dut.r_lfsr), 32'h8000);
    @(negedge clock);
    nReset = 1'b1;

    // Noise control change coinciding with a shift edge
    repeat (3) wait_lfsr_change(200, g);
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (!dut.w_shift && g < 200);
    chk("shift_seen", 32'(dut.w_shift), 32'd1);
    noiseFeedbackType = 1'b1;
    @(posedge clock);
    #1;
    chk("ctrl_reload_coincident", 32'(dut.r_lfsr), 32'h8000);

    // Noise control change away from a shift edge
    repeat (2) wait_lfsr_change(200, g);
    @(negedge clock);
    noiseFeed = 2'b01;
    @(posedge clock);
    #1;
    chk("ctrl_reload_idle", 32'(dut.r_lfsr), 32'h8000);
    @(posedge clock);
    #1;
    chk("ctrl_reload_hold", 32'(dut.r_lfsr), 32'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
